// File: rtl/vga_pixel_arbiter.sv
// vga_pixel_arbiter: grants one of NUM_SRC pixel sources the VGA write port (fixed or round-robin), bounds bursts, registers the pixel.
// Define VGA_ARB_FORCE_SEL_EN to add force_en/force_sel, a bypass that restores the legacy static select mux.
module vga_pixel_arbiter #(
    parameter int NUM_SRC   = 5,
    parameter int X_W       = 8,
    parameter int Y_W       = 7,
    parameter int C_W       = 1,
    parameter int MAX_BURST = 64
) (
    input  logic                                          clock,
    input  logic                                          reset,
    input  logic                                          prio_mode,
`ifdef VGA_ARB_FORCE_SEL_EN
    input  logic                                          force_en,
    input  logic [(NUM_SRC > 1 ? $clog2(NUM_SRC) : 1)-1:0] force_sel,
`endif
    input  logic [NUM_SRC-1:0]                            src_req,
    input  logic [NUM_SRC-1:0]                            src_valid,
    input  logic [NUM_SRC*X_W-1:0]                        src_x,
    input  logic [NUM_SRC*Y_W-1:0]                        src_y,
    input  logic [NUM_SRC*C_W-1:0]                        src_colour,
    output logic [NUM_SRC-1:0]                            src_gnt,
    output logic [NUM_SRC-1:0]                            src_ack,
    output logic [X_W-1:0]                                vga_x,
    output logic [Y_W-1:0]                                vga_y,
    output logic [C_W-1:0]                                vga_colour,
    output logic                                          vga_plot,
    output logic                                          busy
);
    localparam int IW = NUM_SRC > 1 ? $clog2(NUM_SRC) : 1;
    localparam int BW = MAX_BURST > 0 ? $clog2(MAX_BURST + 1) : 1;
    localparam logic [BW-1:0] LAST = BW'(MAX_BURST > 0 ? MAX_BURST - 1 : 0);

    typedef enum logic {IDLE, OWN} state_t;
    state_t state, state_nx;
    logic [IW-1:0] owner, rr_ptr, winner, sel, fsel;
    logic [BW-1:0] burst_cnt;
    logic force_on, sel_ok, own_ack, rel, found;
    int idx;

`ifdef VGA_ARB_FORCE_SEL_EN
    assign force_on = force_en;
    assign fsel = force_sel;
`else
    assign force_on = 1'b0;
    assign fsel = '0;
`endif
    assign busy = state == OWN;
    assign sel = force_on ? fsel : owner;
    assign sel_ok = int'(sel) < NUM_SRC;

    // Round-robin search starts just after the last owner and wraps.
    always_comb begin
        winner = '0;
        found = 1'b0;
        idx = 0;
        for (int i = 0; i < NUM_SRC; i++) begin
            idx = prio_mode ? (int'(rr_ptr) + 1 + i) % NUM_SRC : i;
            if (!found && src_req[idx]) begin
                winner = idx[IW-1:0];
                found = 1'b1;
            end
        end
    end

    always_comb begin
        state_nx = state;
        src_ack = '0;
        own_ack = 1'b0;
        rel = 1'b0;
        if (force_on) begin
            state_nx = IDLE;
            if (sel_ok) src_ack[sel] = src_valid[sel];
        end else if (state == IDLE) begin
            state_nx = |src_req ? OWN : IDLE;
        end else begin
            own_ack = src_req[owner] & src_valid[owner];
            src_ack[owner] = own_ack;
            rel = !src_req[owner] ||
                  (MAX_BURST != 0 && own_ack && burst_cnt == LAST && |(src_req & ~src_gnt));
            state_nx = rel ? IDLE : OWN;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            owner      <= '0;
            rr_ptr     <= IW'(NUM_SRC - 1);
            burst_cnt  <= '0;
            src_gnt    <= '0;
            vga_x      <= '0;
            vga_y      <= '0;
            vga_colour <= '0;
            vga_plot   <= 1'b0;
        end else begin
            state    <= state_nx;
            vga_plot <= |src_ack;
            if (force_on ? sel_ok : own_ack) begin
                vga_x      <= src_x[int'(sel)*X_W +: X_W];
                vga_y      <= src_y[int'(sel)*Y_W +: Y_W];
                vga_colour <= src_colour[int'(sel)*C_W +: C_W];
            end
            if (force_on) begin
                src_gnt   <= '0;
                burst_cnt <= '0;
            end else if (state == IDLE) begin
                if (|src_req) begin
                    owner   <= winner;
                    src_gnt <= NUM_SRC'(1) << winner;
                end
            end else if (rel) begin
                src_gnt   <= '0;
                burst_cnt <= '0;
                rr_ptr    <= owner;
            end else if (own_ack && (MAX_BURST == 0 || burst_cnt != LAST)) begin
                burst_cnt <= burst_cnt + 1'b1;
            end
        end
    end
endmodule

// File: doc/vga_pixel_arbiter.md
Name: vga_pixel_arbiter

Overview:
- Parametrised N-source pixel arbiter for the VGA adapter write port; successor to the static select mux.
- Each drawing FSM (background, pacman, win/gameover screens, exit) requests the bus. The block grants one owner with fixed or round-robin priority, bounds its burst length, and forwards accepted pixels.
- Output x/y/colour/plot is registered and drives the VGA adapter directly.

Parameters:
- NUM_SRC, 5, number of pixel sources
- X_W, 8, x coordinate width
- Y_W, 7, y coordinate width
- C_W, 1, colour width
- MAX_BURST, 64, pixels accepted before forced release when others wait; 0 = unlimited

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous active-high reset
- prio_mode  in  1  0 = fixed priority (lowest index wins), 1 = round-robin
- src_req  in  NUM_SRC  source wants the bus; held for the whole sprite/screen
- src_valid  in  NUM_SRC  source presents a pixel this cycle
- src_x  in  NUM_SRC*X_W  flat x buses; source i occupies bits [i*X_W +: X_W]
- src_y  in  NUM_SRC*Y_W  flat y buses, same packing
- src_colour  in  NUM_SRC*C_W  flat colour buses, same packing
- src_gnt  out  NUM_SRC  registered one-hot owner
- src_ack  out  NUM_SRC  combinational: pixel consumed this cycle
- vga_x  out  X_W  registered pixel x
- vga_y  out  Y_W  registered pixel y
- vga_colour  out  C_W  registered pixel colour
- vga_plot  out  1  registered write enable
- busy  out  1  high while in OWN

Behaviour:
- Reset value is 0 for all outputs, burst_cnt and the FSM state (IDLE).
- rr_ptr resets to NUM_SRC-1, so source 0 has first priority in round-robin mode.
- FSM IDLE:
  - If src_req is nonzero, pick the winner and go to OWN.
  - src_gnt shows the winner on the next edge, giving 1 cycle of arbitration latency.
  - Fixed mode: the lowest set index wins.
  - Round-robin mode: search starts at rr_ptr+1 and wraps modulo NUM_SRC.
- FSM OWN:
  - src_ack[o] = src_gnt[o] & src_req[o] & src_valid[o]. All other ack bits are 0.
  - On ack, the next edge loads vga_x/y/colour from source o, sets vga_plot=1 and increments burst_cnt.
  - Otherwise vga_plot=0 and vga_x/y/colour hold their values.
  - Pixel latency is exactly 1 cycle from ack to plot.
- Release from OWN to IDLE happens on either condition:
  - src_req[o]=0. No ack that cycle, even if valid is high.
  - MAX_BURST≠0 and burst_cnt==MAX_BURST-1 with an ack this cycle and any other req bit set. The final pixel is still accepted.
- On release:
  - src_gnt clears, burst_cnt clears, rr_ptr<=o.
  - One IDLE cycle always follows before the next grant.
- Burst limit with no other requester: the owner keeps the bus and burst_cnt saturates at MAX_BURST-1.
- Fixed mode after a forced release: the same owner may win again if it is still the lowest requester.
- Width rules:
  - burst_cnt is $clog2(MAX_BURST+1) bits.
  - Source indices are $clog2(NUM_SRC) bits; minimum 1 bit.
- Changing prio_mode mid-OWN does not affect the current owner. The new mode applies at the next IDLE decision.
- Async reset mid-burst: all outputs clear immediately and any in-flight pixel is dropped.

Optional Feature:
- Macro: VGA_ARB_FORCE_SEL_EN.
- When defined, two extra inputs exist:
  - force_en, 1 bit.
  - force_sel, $clog2(NUM_SRC) bits.
- While force_en=1, the static legacy mux behaviour applies:
  - Arbitration is bypassed; FSM is held in IDLE; src_gnt=0.
  - src_ack[force_sel]=src_valid[force_sel].
  - Output registers load source force_sel each cycle, with vga_plot=src_valid[force_sel].
  - force_sel>=NUM_SRC gives vga_plot=0 and no ack.
- Deasserting force_en resumes normal arbitration from IDLE.
- When undefined: the ports are absent and the block behaves as described above only.

Test Plan:
- Reset, then src_req=5'b00001 with valid every cycle.
  - src_gnt=00001 after 1 cycle.
  - src_ack held high.
  - Source 0 pixels appear on vga_* 1 cycle after each ack, with vga_plot=1.
- prio_mode=0, src_req=5'b10110 held, MAX_BURST=4.
  - Source 1 is granted.
  - After 4 acks it releases, idles 1 cycle, then source 1 is regranted.
- prio_mode=1, same request pattern, MAX_BURST=4.
  - Grant order is 1, 2, 4, 1, each with 4 pixels and one IDLE gap between owners.
- Owner drops src_req while src_valid=1.
  - No ack that cycle; vga_plot=0 next cycle.
  - src_gnt clears; busy=0.
- Assert reset mid-burst after 2 pixels.
  - vga_plot, src_gnt and busy go to 0 without waiting for a clock edge.
  - After reset, source 0 has priority.
- VGA_ARB_FORCE_SEL_EN, force_en=1, force_sel=3, src_valid[3] toggling.
  - vga_plot follows src_valid[3] with 1-cycle delay; vga_x follows src_x[3].
  - src_gnt=0 throughout.
